cp_insert: RTL and testbench

Cyclic-prefix insertion stage of the OFDM transmit chain. Sits directly downstream of the IFFT core and upstream of the sample-rate playback stage. Buffers each nfft-sample time-domain symbol in a ping-pong RAM, then emits the last cp_len samples followed by the full symbol as one AXI-Stream packet of nfft+cp_len samples.

---
 rtl/cp_insert_if.sv | 12 +
 rtl/cp_insert.sv | 249 ++++++++++++++++++++++++
 tb/tb_cp_insert.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp_insert_if.sv
// AXI-Stream style sample bus shared by the IFFT side and the playback side.
interface cp_insert_if #(
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/cp_insert.sv
// Cyclic-prefix insertion: buffers one nfft-sample symbol per bank of a ping-pong RAM and
// replays it as the last cp_len samples followed by the whole symbol, as one packet.
module cp_insert #(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned MAX_NFFT_LOG2 = 12
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        config_start,
  input  logic [4:0]  nfft,
  input  logic [15:0] cp_len,
  cp_insert_if.slave  s_axis,
  cp_insert_if.master m_axis,
  output logic        cfg_err,
  output logic        frame_err
);

  localparam int unsigned AW      = MAX_NFFT_LOG2;
  localparam int unsigned Depth   = 2 ** AW;
  localparam logic [4:0]  MinLog2 = 5'd3;
  localparam logic [4:0]  MaxLog2 = 5'(MAX_NFFT_LOG2);

  typedef logic [AW:0]   len_t;   // holds N up to 2^AW
  typedef logic [AW+1:0] rcnt_t;  // holds N+CP-1 < 2N

  typedef enum logic [1:0] {
    BkEmpty,
    BkFilling,
    BkFull,
    BkDraining
  } bank_st_e;

  // Configuration
  logic          configured_q, configured_d;
  logic [4:0]    nlog_q, nlog_d;
  logic [AW-1:0] cp_q, cp_d;
  logic          cfg_err_q, cfg_err_d;
  logic          frame_err_q, frame_err_d;

  // Bank bookkeeping
  bank_st_e bank_q [2];
  bank_st_e bank_d [2];
  logic     wr_sel_q, wr_sel_d;
  logic     rd_sel_q, rd_sel_d;
  logic     rel_sel_q, rel_sel_d;  // bank whose packet is next to finish at the output

  // Writer / reader counters
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic          rd_busy_q, rd_busy_d;
  rcnt_t         rd_cnt_q, rd_cnt_d;

  // RAM read stage and 2-entry output skid (out_* is the head and drives the port)
  logic              ram_vld_q, ram_vld_d;
  logic              ram_last_q, ram_last_d;
  logic [DATA_W-1:0] ram_data_q;
  logic              out_vld_q, out_vld_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              sk_vld_q, sk_vld_d;
  logic              sk_last_q, sk_last_d;
  logic [DATA_W-1:0] sk_data_q, sk_data_d;

  logic [DATA_W-1:0] mem_q [2*Depth];

  // Combinational helpers
  len_t          n_val, n_m1, new_n;
  logic          s_ready, wr_en, wr_last;
  logic          pop, room, start, rd_en, rd_last, idle;
  logic [1:0]    occ;
  rcnt_t         cur_cnt;
  logic [AW-1:0] rd_addr;

  assign n_val = len_t'(1) << nlog_q;
  assign n_m1  = n_val - len_t'(1);

  // Next-state for configuration, bank states, writer, reader and output skid
  always_comb begin
    configured_d = configured_q;
    nlog_d       = nlog_q;
    cp_d         = cp_q;
    cfg_err_d    = cfg_err_q;
    frame_err_d  = frame_err_q;
    bank_d       = bank_q;
    wr_sel_d     = wr_sel_q;
    rd_sel_d     = rd_sel_q;
    rel_sel_d    = rel_sel_q;
    wr_cnt_d     = wr_cnt_q;
    rd_busy_d    = rd_busy_q;
    rd_cnt_d     = rd_cnt_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    sk_data_d    = sk_data_q;
    sk_last_d    = sk_last_q;
    new_n        = '0;

    // Writer: fill the selected bank, close the frame on count regardless of tlast
    s_ready = configured_q & ((bank_q[wr_sel_q] == BkEmpty) | (bank_q[wr_sel_q] == BkFilling));
    wr_en   = s_axis.tvalid & s_ready;
    wr_last = (len_t'(wr_cnt_q) == n_m1);
    if (wr_en) begin
      if (s_axis.tlast != wr_last) frame_err_d = 1'b1;
      if (wr_last) begin
        bank_d[wr_sel_q] = BkFull;
        wr_sel_d         = ~wr_sel_q;
        wr_cnt_d         = '0;
      end else begin
        bank_d[wr_sel_q] = BkFilling;
        wr_cnt_d         = wr_cnt_q + AW'(1);
      end
    end

    // Reader: issue a read only when the skid can absorb it, counting the read in flight
    pop     = out_vld_q & m_axis.tready;
    occ     = 2'(out_vld_q) + 2'(sk_vld_q) + 2'(ram_vld_q);
    room    = (occ - 2'(pop)) < 2'd2;
    start   = ~rd_busy_q & (bank_q[rd_sel_q] == BkFull);
    cur_cnt = start ? '0 : rd_cnt_q;
    rd_last = (cur_cnt == rcnt_t'(n_val) + rcnt_t'(cp_q) - rcnt_t'(1));
    rd_en   = (rd_busy_q | start) & room;
    // Modulo-N walk starting CP samples before the end gives prefix then body
    rd_addr = AW'((cur_cnt - rcnt_t'(cp_q)) & rcnt_t'(n_m1));
    if (start) begin
      bank_d[rd_sel_q] = BkDraining;
      rd_busy_d        = 1'b1;
      rd_cnt_d         = '0;
    end
    if (rd_en) begin
      if (rd_last) begin
        rd_busy_d = 1'b0;
        rd_sel_d  = ~rd_sel_q;
        rd_cnt_d  = '0;
      end else begin
        rd_cnt_d = cur_cnt + rcnt_t'(1);
      end
    end
    ram_vld_d  = rd_en;
    ram_last_d = rd_en & rd_last;

    // Output skid: head advances on handshake, new RAM data fills the first free slot
    out_vld_d = out_vld_q & ~pop;
    sk_vld_d  = sk_vld_q;
    if (pop && sk_vld_q) begin
      out_vld_d  = 1'b1;
      out_data_d = sk_data_q;
      out_last_d = sk_last_q;
      sk_vld_d   = 1'b0;
    end
    if (ram_vld_q) begin
      if (!out_vld_d) begin
        out_vld_d  = 1'b1;
        out_data_d = ram_data_q;
        out_last_d = ram_last_q;
      end else begin
        sk_vld_d  = 1'b1;
        sk_data_d = ram_data_q;
        sk_last_d = ram_last_q;
      end
    end

    // Bank is free once its final sample has left the block
    if (pop && out_last_q) begin
      bank_d[rel_sel_q] = BkEmpty;
      rel_sel_d         = ~rel_sel_q;
    end

    // Configuration only while nothing is buffered or in flight
    idle = (bank_q[0] == BkEmpty) & (bank_q[1] == BkEmpty) & ~rd_busy_q &
           ~ram_vld_q & ~out_vld_q & ~sk_vld_q;
    if (config_start && idle) begin
      if (nfft < MinLog2 || nfft > MaxLog2) begin
        cfg_err_d = 1'b1;
      end else begin
        new_n        = len_t'(1) << nfft;
        configured_d = 1'b1;
        nlog_d       = nfft;
        frame_err_d  = 1'b0;
        wr_cnt_d     = '0;
        if (cp_len >= 16'(new_n)) begin
          cp_d      = '0;
          cfg_err_d = 1'b1;
        end else begin
          cp_d      = AW'(cp_len);
          cfg_err_d = 1'b0;
        end
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge aclk) begin
    if (areset) begin
      configured_q <= 1'b0;
      nlog_q       <= '0;
      cp_q         <= '0;
      cfg_err_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      bank_q       <= '{BkEmpty, BkEmpty};
      wr_sel_q     <= 1'b0;
      rd_sel_q     <= 1'b0;
      rel_sel_q    <= 1'b0;
      wr_cnt_q     <= '0;
      rd_busy_q    <= 1'b0;
      rd_cnt_q     <= '0;
      ram_vld_q    <= 1'b0;
      ram_last_q   <= 1'b0;
      out_vld_q    <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      sk_vld_q     <= 1'b0;
      sk_last_q    <= 1'b0;
      sk_data_q    <= '0;
    end else begin
      configured_q <= configured_d;
      nlog_q       <= nlog_d;
      cp_q         <= cp_d;
      cfg_err_q    <= cfg_err_d;
      frame_err_q  <= frame_err_d;
      bank_q       <= bank_d;
      wr_sel_q     <= wr_sel_d;
      rd_sel_q     <= rd_sel_d;
      rel_sel_q    <= rel_sel_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_busy_q    <= rd_busy_d;
      rd_cnt_q     <= rd_cnt_d;
      ram_vld_q    <= ram_vld_d;
      ram_last_q   <= ram_last_d;
      out_vld_q    <= out_vld_d;
      out_last_q   <= out_last_d;
      out_data_q   <= out_data_d;
      sk_vld_q     <= sk_vld_d;
      sk_last_q    <= sk_last_d;
      sk_data_q    <= sk_data_d;
    end
  end

  // Simple dual-port sample RAM, registered read
  always_ff @(posedge aclk) begin
    if (wr_en) mem_q[{wr_sel_q, wr_cnt_q}] <= s_axis.tdata;
    if (rd_en) ram_data_q <= mem_q[{rd_sel_q, rd_addr}];
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = out_vld_q;
  assign m_axis.tdata  = out_data_q;
  assign m_axis.tlast  = out_last_q;
  assign cfg_err       = cfg_err_q;
  assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_cp_insert.sv
// Randomized scoreboard bench for cp_insert: a symbol-level model queues each expected
// packet when its frame is issued; a negedge monitor pops and compares every output beat.
module tb_cp_insert;

  logic        aclk = 1'b0;
  logic        areset;
  logic        config_start;
  logic [4:0]  nfft;
  logic [15:0] cp_len;
  logic        cfg_err;
  logic        frame_err;

  cp_insert_if #(.DATA_W(32)) s_if ();
  cp_insert_if #(.DATA_W(32)) m_if ();

  cp_insert #(
    .DATA_W       (32),
    .MAX_NFFT_LOG2(12)
  ) dut (
    .aclk        (aclk),
    .areset      (areset),
    .config_start(config_start),
    .nfft        (nfft),
    .cp_len      (cp_len),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .cfg_err     (cfg_err),
    .frame_err   (frame_err)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t exp_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state
  bit m_cfg = 0;
  int m_n   = 0;
  int m_cp  = 0;
  bit m_cfg_err = 0;
  bit m_frame_err = 0;

  bit rdy_rand = 0;
  int out_cnt = 0;
  int gap_cnt = 0;
  bit gap_on = 0;
  bit seen_any = 0;
  bit stall_seen = 0;
  int hs_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Downstream ready: always high or a fair coin per cycle
  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      m_if.tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compare every handshake against the scoreboard, and check stall stability
  initial begin
    bit          prev_stall;
    logic [31:0] prev_d;
    logic        prev_l;
    exp_t        e;
    prev_stall = 0;
    prev_d = '0;
    prev_l = 0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          check("stall_valid_held", 64'(m_if.tvalid), 64'd1);
          check("stall_data_held", {31'd0, m_if.tdata, m_if.tlast}, {31'd0, prev_d, prev_l});
        end
        if (gap_on && seen_any && !m_if.tvalid && exp_q.size() > 0) gap_cnt++;
        if (m_if.tvalid && m_if.tready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: got %0h, expected no output", m_if.tdata);
          end else begin
            e = exp_q.pop_front();
            check("out_data", 64'(m_if.tdata), 64'(e.d));
            check("out_last", 64'(m_if.tlast), 64'(e.l));
          end
          out_cnt++;
          if (gap_on) seen_any = 1;
        end
        prev_stall = m_if.tvalid && !m_if.tready;
        prev_d = m_if.tdata;
        prev_l = m_if.tlast;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    areset = 1'b1;
    exp_q.delete();
    @(posedge aclk);
    #1;
    areset = 1'b0;
    m_cfg = 0;
    m_cfg_err = 0;
    m_frame_err = 0;
  endtask

  task automatic configure(input int nf, input int cl);
    config_start = 1'b1;
    nfft = 5'(nf);
    cp_len = 16'(cl);
    @(posedge aclk);
    #1;
    config_start = 1'b0;
    if (nf >= 3 && nf <= 12) begin
      m_cfg = 1;
      m_n = 1 << nf;
      m_frame_err = 0;
      if (cl >= m_n) begin
        m_cp = 0;
        m_cfg_err = 1;
      end else begin
        m_cp = cl;
        m_cfg_err = 0;
      end
    end else begin
      m_cfg_err = 1;
    end
    @(negedge aclk);
    check("cfg_err", 64'(cfg_err), 64'(m_cfg_err));
    check("frame_err_after_cfg", 64'(frame_err), 64'(m_frame_err));
    @(posedge aclk);
    #1;
  endtask

  // Issue one frame: queue its expected packet, then drive it with optional idle gaps
  task automatic send_frame(input int base, input bit rnd, input int last_pos, input bit gaps);
    logic [31:0] smp [$];
    exp_t e;
    bit hs;
    int wt;
    for (int i = 0; i < m_n; i++) smp.push_back(rnd ? $urandom : 32'(base + i));
    for (int i = 0; i < m_cp; i++) begin
      e.d = smp[m_n - m_cp + i];
      e.l = 1'b0;
      exp_q.push_back(e);
    end
    for (int i = 0; i < m_n; i++) begin
      e.d = smp[i];
      e.l = (i == m_n - 1);
      exp_q.push_back(e);
    end
    if (last_pos != m_n - 1) m_frame_err = 1;
    for (int i = 0; i < m_n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_if.tvalid = 1'b0;
        @(posedge aclk);
        #1;
      end
      s_if.tvalid = 1'b1;
      s_if.tdata = smp[i];
      s_if.tlast = (i == last_pos);
      wt = 0;
      do begin
        @(negedge aclk);
        hs = s_if.tready;
        if (!hs) stall_seen = 1;
        @(posedge aclk);
        #1;
        wt++;
      end while (!hs && wt < 4000);
      if (!hs) begin
        n_tests++;
        n_fail++;
        $display("FAIL input_accept: got tready stuck low, expected sample %0d accepted", i);
        s_if.tvalid = 1'b0;
        return;
      end
      hs_cyc = cyc;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int wt;
    wt = 0;
    while (exp_q.size() > 0 && wt < 5000) begin
      @(posedge aclk);
      wt++;
    end
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge aclk);
    #1;
  endtask

  initial begin
    int lat;
    int o0;
    int wt;
    areset = 1'b1;
    config_start = 1'b0;
    nfft = '0;
    cp_len = '0;
    s_if.tvalid = 1'b0;
    s_if.tdata = '0;
    s_if.tlast = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;

    // Reset state
    @(negedge aclk);
    check("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    check("rst_m_tdata", 64'(m_if.tdata), 64'd0);
    check("rst_m_tlast", 64'(m_if.tlast), 64'd0);
    check("rst_s_tready", 64'(s_if.tready), 64'd0);
    check("rst_cfg_err", 64'(cfg_err), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    @(posedge aclk);
    #1;

    // Ramp with a 2-sample prefix, and first-output latency
    configure(3, 2);
    send_frame(0, 0, 7, 0);
    lat = -1;
    for (int j = 0; j < 8; j++) begin
      @(negedge aclk);
      if (m_if.tvalid) begin
        lat = cyc - hs_cyc;
        break;
      end
    end
    check("first_latency", 64'(lat), 64'd2);
    wait_drain("ramp_drain");

    // Three back-to-back frames, gapless output, input back-pressure
    configure(4, 4);
    gap_on = 1;
    seen_any = 0;
    gap_cnt = 0;
    stall_seen = 0;
    o0 = out_cnt;
    send_frame(32'h100, 0, 15, 0);
    send_frame(32'h200, 0, 15, 0);
    send_frame(32'h300, 0, 15, 0);
    wait_drain("b2b_drain");
    gap_on = 0;
    check("b2b_gaps", 64'(gap_cnt), 64'd0);
    check("b2b_count", 64'(out_cnt - o0), 64'd60);
    check("b2b_backpressure", 64'(stall_seen), 64'd1);

    // Random downstream stalls and input gaps
    configure(6, 16);
    rdy_rand = 1;
    for (int f = 0; f < 4; f++) send_frame(0, 1, 63, 1);
    wait_drain("rand_drain");
    rdy_rand = 0;

    // Pass-through and oversized prefix
    configure(4, 0);
    send_frame(0, 1, 15, 1);
    send_frame(0, 1, 15, 1);
    wait_drain("pass_drain");
    configure(3, 8);
    o0 = out_cnt;
    send_frame(0, 1, 7, 0);
    wait_drain("bigcp_drain");
    check("bigcp_count", 64'(out_cnt - o0), 64'd8);

    // Illegal nfft while unconfigured
    do_reset();
    configure(13, 0);
    s_if.tvalid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge aclk);
      check("unconf_tready", 64'(s_if.tready), 64'd0);
    end
    @(posedge aclk);
    #1;
    s_if.tvalid = 1'b0;

    // Misplaced and missing tlast
    configure(3, 3);
    send_frame(32'h50, 0, 5, 0);
    wait_drain("early_last_drain");
    check("frame_err_early", 64'(frame_err), 64'(m_frame_err));
    send_frame(32'h60, 0, -1, 0);
    wait_drain("no_last_drain");
    check("frame_err_sticky", 64'(frame_err), 64'(m_frame_err));
    configure(3, 3);

    // Reset in the middle of a packet, then a fresh packet
    configure(4, 4);
    o0 = out_cnt;
    send_frame(0, 1, 15, 0);
    wt = 0;
    while (out_cnt - o0 < 5 && wt < 200) begin
      @(posedge aclk);
      wt++;
    end
    #1;
    check("mid_pkt_reached", 64'(out_cnt - o0 >= 5), 64'd1);
    do_reset();
    @(negedge aclk);
    check("mid_rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    check("mid_rst_m_tdata", 64'(m_if.tdata), 64'd0);
    check("mid_rst_m_tlast", 64'(m_if.tlast), 64'd0);
    check("mid_rst_s_tready", 64'(s_if.tready), 64'd0);
    @(posedge aclk);
    #1;
    configure(4, 4);
    send_frame(0, 1, 15, 0);
    wait_drain("post_rst_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
